musa_multicycle_ctrl: RTL



---
 rtl/musa_multicycle_ctrl.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/musa_multicycle_ctrl.sv
// Multicycle control sequencer for the MUSA ID stage: stage counter, opcode decode,
// stack strobes, HALT/resume handling, sticky illegal-opcode flag and retire counter.
module musa_multicycle_ctrl #(
    parameter int NUM_STAGES   = 5,
    parameter int STAGE_W      = 3,
    parameter int DECODE_STAGE = 1,
    parameter int MEM_STAGE    = 2,
    parameter int CNT_W        = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic               stall,
    input  logic               resume,
    output logic [STAGE_W-1:0] stage,
    output logic               pc_write,
    output logic               reg_dst,
    output logic               mem_read,
    output logic               mem_to_reg,
    output logic               mem_write,
    output logic               reg_write,
    output logic [2:0]         alu_op,
    output logic [2:0]         pc_src,
    output logic [1:0]         data_a_select,
    output logic [1:0]         data_b_select,
    output logic               push,
    output logic               pop,
    output logic               halted,
    output logic               illegal_op,
    output logic [CNT_W-1:0]   instr_count
);

    typedef enum logic {RUN, HALTED} state_t;

    typedef struct packed {
        logic       regDst;
        logic       memRead;
        logic       memToReg;
        logic       memWrite;
        logic       regWrite;
        logic [2:0] aluOp;
        logic [2:0] pcSrc;
        logic [1:0] aSel;
        logic [1:0] bSel;
        logic       pushType;
        logic       popType;
        logic       haltType;
        logic       illegal;
    } ctrl_t;

    localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(NUM_STAGES - 1);
    localparam logic [STAGE_W-1:0] DEC_STAGE  = STAGE_W'(DECODE_STAGE);
    localparam logic [STAGE_W-1:0] PRE_MEM    = STAGE_W'(MEM_STAGE - 1);

    function automatic ctrl_t nopCtrl();
        ctrl_t c;
        c       = '0;
        c.aluOp = 3'b010;
        c.pcSrc = 3'b010;
        return c;
    endfunction

    function automatic ctrl_t decode(input logic [5:0] op);
        ctrl_t c;
        c = nopCtrl();
        case (op)
            6'b000000, 6'b011100, 6'b000101: begin
                c.regDst   = 1'b1;
                c.regWrite = 1'b1;
                c.aSel     = 2'b10;
                c.bSel     = 2'b01;
            end
            6'b001000, 6'b001001, 6'b001100, 6'b001101: begin
                c.regWrite = 1'b1;
                c.aSel     = 2'b10;
                case (op)
                    6'b001001: c.aluOp = 3'b001;
                    6'b001100: c.aluOp = 3'b011;
                    6'b001101: c.aluOp = 3'b100;
                    default:   c.aluOp = 3'b000;
                endcase
            end
            6'b100011: begin
                c.memRead  = 1'b1;
                c.memToReg = 1'b1;
                c.regWrite = 1'b1;
                c.aluOp    = 3'b000;
                c.aSel     = 2'b10;
            end
            6'b101011: begin
                c.memWrite = 1'b1;
                c.aluOp    = 3'b000;
                c.aSel     = 2'b10;
            end
            6'b010001: begin
                c.aluOp = 3'b000;
                c.pcSrc = 3'b001;
            end
            6'b000010: begin
                c.aluOp = 3'b000;
                c.pcSrc = 3'b011;
                c.bSel  = 2'b10;
            end
            6'b000100: begin
                c.aluOp = 3'b101;
                c.pcSrc = 3'b001;
                c.aSel  = 2'b10;
            end
            6'b000011: begin
                c.aluOp    = 3'b000;
                c.pcSrc    = 3'b001;
                c.pushType = 1'b1;
            end
            6'b000001: begin
                c.aluOp   = 3'b000;
                c.pcSrc   = 3'b000;
                c.popType = 1'b1;
            end
            6'b111111: begin
                c.aluOp    = 3'b000;
                c.pcSrc    = 3'b101;
                c.haltType = 1'b1;
            end
            default: c.illegal = 1'b1;
        endcase
        return c;
    endfunction

    state_t             r_state;
    logic [STAGE_W-1:0] r_stage;
    ctrl_t              r_ctrl;
    logic               r_pcWrite;
    logic               r_push;
    logic               r_pop;
    logic               r_halted;
    logic               r_illegal;
    logic [CNT_W-1:0]   r_count;

    ctrl_t w_dec;
    ctrl_t w_cur;

    // The stack strobe is decided on the edge entering MEM_STAGE; when that edge is
    // also the decode edge the freshly decoded type must be used instead of the latch.
    assign w_dec = decode(opcode);
    assign w_cur = (r_stage == DEC_STAGE) ? w_dec : r_ctrl;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= RUN;
            r_stage   <= '0;
            r_ctrl    <= nopCtrl();
            r_pcWrite <= 1'b0;
            r_push    <= 1'b0;
            r_pop     <= 1'b0;
            r_halted  <= 1'b0;
            r_illegal <= 1'b0;
            r_count   <= '0;
        end else begin
            r_pcWrite <= 1'b0;
            r_push    <= 1'b0;
            r_pop     <= 1'b0;
            case (r_state)
                RUN: begin
                    if (!stall) begin
                        r_stage <= (r_stage == LAST_STAGE) ? '0 : r_stage + STAGE_W'(1);
                        if (r_stage == DEC_STAGE) begin
                            r_ctrl <= w_dec;
                            if (w_dec.illegal) r_illegal <= 1'b1;
                        end
                        if (r_stage == PRE_MEM) begin
                            r_push <= w_cur.pushType;
                            r_pop  <= w_cur.popType;
                        end
                        if (r_stage == LAST_STAGE) begin
                            r_count <= r_count + CNT_W'(1);
                            if (r_ctrl.haltType) begin
                                r_state  <= HALTED;
                                r_halted <= 1'b1;
                            end else begin
                                r_pcWrite <= 1'b1;
                            end
                        end
                    end
                end
                HALTED: begin
                    if (resume) begin
                        r_state  <= RUN;
                        r_halted <= 1'b0;
                    end
                end
                default: r_state <= RUN;
            endcase
        end
    end

    assign stage         = r_stage;
    assign pc_write      = r_pcWrite;
    assign reg_dst       = r_ctrl.regDst;
    assign mem_read      = r_ctrl.memRead;
    assign mem_to_reg    = r_ctrl.memToReg;
    assign mem_write     = r_ctrl.memWrite;
    assign reg_write     = r_ctrl.regWrite;
    assign alu_op        = r_ctrl.aluOp;
    assign pc_src        = r_ctrl.pcSrc;
    assign data_a_select = r_ctrl.aSel;
    assign data_b_select = r_ctrl.bSel;
    assign push          = r_push;
    assign pop           = r_pop;
    assign halted        = r_halted;
    assign illegal_op    = r_illegal;
    assign instr_count   = r_count;

endmodule
